// File: rtl/cpld_parity_pkg.sv
// Shared definitions for the XOR-parity serial link (receiver and transmitter).
package cpld_parity_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DATA = 2'b01,
        ST_PAR  = 2'b10
    } state_e;

    localparam int unsigned PAR_EVEN = 0;
    localparam int unsigned PAR_ODD  = 1;

    // Bits needed to represent values 0..v-1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/cpld_sipo_shreg.sv
// Serial-in/parallel-out shift register with a load-first (clearing) input and selectable direction.
module cpld_sipo_shreg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         load_i,
    input  logic         msb_first_i,
    input  logic         si_i,
    output logic [W-1:0] q_o
);

    localparam int unsigned TOP = W - 1;

    logic [W-1:0] q_q;
    logic [W-1:0] load_val;
    logic [W-1:0] shift_val;

    // MSB-first shifts toward the MSB with new bits at [0]; LSB-first enters at [W-1] and moves down.
    always_comb begin
        load_val  = msb_first_i ? W'(si_i) : (W'(si_i) << TOP);
        shift_val = msb_first_i ? ((q_q << 1) | W'(si_i))
                                : ((q_q >> 1) | (W'(si_i) << TOP));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else if (load_i) begin
            q_q <= load_val;
        end else if (en_i) begin
            q_q <= shift_val;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/cpld_parity_rx.sv
// Serial XOR-parity receiver: deserialises DATA_W bits plus parity and flags parity/framing errors.
module cpld_parity_rx
    import cpld_parity_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ODD       = PAR_EVEN,
    parameter int unsigned MSB_FIRST = 0
) (
    input  logic              CK,
    input  logic              CD,
    input  logic              SI,
    input  logic              SV,
    input  logic              SOF,
    output logic [DATA_W-1:0] DO,
    output logic              DV,
    output logic              PERR,
    output logic              FERR,
    output logic              BUSY
);

    localparam int unsigned     CNT_W     = clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);
    localparam logic            PAR_SENSE = (ODD == PAR_ODD);
    localparam logic            MSB_SEL   = (MSB_FIRST != 0);

    state_e              state_q, state_d;
    logic                acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   do_q, do_d;
    logic                dv_q, dv_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;
    logic                busy_q;
    logic                sr_en, sr_load;
    logic [DATA_W-1:0]   sr_q;
    logic [CNT_W-1:0]    cnt_inc;

    cpld_sipo_shreg #(.W(DATA_W)) u_shreg (
        .clk         (CK),
        .rst         (CD),
        .en_i        (sr_en),
        .load_i      (sr_load),
        .msb_first_i (MSB_SEL),
        .si_i        (SI),
        .q_o         (sr_q)
    );

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        do_d    = do_q;
        dv_d    = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        sr_en   = 1'b0;
        sr_load = 1'b0;
        if (SV) begin
            if (SOF) begin
                // SOF always restarts; a frame in flight is reported as aborted.
                ferr_d  = (state_q != ST_IDLE);
                sr_load = 1'b1;
                acc_d   = SI;
                cnt_d   = CNT_W'(1);
                state_d = (DATA_W == 1) ? ST_PAR : ST_DATA;
            end else begin
                unique case (state_q)
                    ST_IDLE: ;
                    ST_DATA: begin
                        sr_en = 1'b1;
                        acc_d = acc_q ^ SI;
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_LAST) state_d = ST_PAR;
                    end
                    ST_PAR: begin
                        do_d    = sr_q;
                        dv_d    = 1'b1;
                        perr_d  = acc_q ^ SI ^ PAR_SENSE;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge CK or posedge CD) begin
        if (CD) begin
            state_q <= ST_IDLE;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            do_q    <= '0;
            dv_q    <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            do_q    <= do_d;
            dv_q    <= dv_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign DO   = do_q;
    assign DV   = dv_q;
    assign PERR = perr_q;
    assign FERR = ferr_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_cpld_parity_rx.sv
// Directed bench for cpld_parity_rx: even/odd LSB-first 8-bit receivers and an MSB-first 4-bit receiver.
module tb_cpld_parity_rx;

    logic       CK = 1'b0;
    logic       CD = 1'b1;
    logic       SI = 1'b0;
    logic       SV = 1'b0;
    logic       SOF = 1'b0;

    logic [7:0] do0, do1;
    logic [3:0] do2;
    logic       dv0, perr0, ferr0, busy0;
    logic       dv1, perr1, ferr1, busy1;
    logic       dv2, perr2, ferr2, busy2;

    int n_checks = 0;
    int n_pass   = 0;
    int dv_cnt0  = 0;
    int ferr_cnt0 = 0;
    int dv_base, ferr_base;

    always #5 CK = ~CK;

    cpld_parity_rx #(.DATA_W(8), .ODD(0), .MSB_FIRST(0)) dut_even (
        .CK(CK), .CD(CD), .SI(SI), .SV(SV), .SOF(SOF),
        .DO(do0), .DV(dv0), .PERR(perr0), .FERR(ferr0), .BUSY(busy0)
    );

    cpld_parity_rx #(.DATA_W(8), .ODD(1), .MSB_FIRST(0)) dut_odd (
        .CK(CK), .CD(CD), .SI(SI), .SV(SV), .SOF(SOF),
        .DO(do1), .DV(dv1), .PERR(perr1), .FERR(ferr1), .BUSY(busy1)
    );

    cpld_parity_rx #(.DATA_W(4), .ODD(0), .MSB_FIRST(1)) dut_msb4 (
        .CK(CK), .CD(CD), .SI(SI), .SV(SV), .SOF(SOF),
        .DO(do2), .DV(dv2), .PERR(perr2), .FERR(ferr2), .BUSY(busy2)
    );

    always @(negedge CK) begin
        if (dv0)   dv_cnt0   <= dv_cnt0 + 1;
        if (ferr0) ferr_cnt0 <= ferr_cnt0 + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic drive(input logic sv, input logic sof, input logic si);
        @(negedge CK);
        SV  = sv;
        SOF = sof;
        SI  = si;
    endtask

    task automatic send_frame(input logic [15:0] data, input int nbits, input bit msb,
                              input logic par, input int gap);
        logic b;
        for (int i = 0; i < nbits; i++) begin
            b = msb ? data[nbits-1-i] : data[i];
            drive(1'b1, (i == 0), b);
            for (int g = 0; g < gap; g++) begin
                drive(1'b0, 1'b0, 1'b0);
                #1 check_eq("busy_in_gap", 32'(busy0), 32'd1);
            end
        end
        drive(1'b1, 1'b0, par);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge CK);
        check_eq("rst_do",   32'(do0),   32'h0);
        check_eq("rst_dv",   32'(dv0),   32'd0);
        check_eq("rst_perr", 32'(perr0), 32'd0);
        check_eq("rst_ferr", 32'(ferr0), 32'd0);
        check_eq("rst_busy", 32'(busy0), 32'd0);
        CD = 1'b0;

        // Stray bits without SOF are ignored
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        check_eq("stray_busy", 32'(busy0), 32'd0);

        // 0xA5 even parity bit 0
        send_frame(16'hA5, 8, 1'b0, 1'b0, 0);
        check_eq("a5_busy_par", 32'(busy0), 32'd1);
        drive(1'b0, 1'b0, 1'b0);
        check_eq("a5_do",    32'(do0),   32'hA5);
        check_eq("a5_dv",    32'(dv0),   32'd1);
        check_eq("a5_perr",  32'(perr0), 32'd0);
        check_eq("a5_busy",  32'(busy0), 32'd0);
        check_eq("a5_odd_perr", 32'(perr1), 32'd1);
        drive(1'b0, 1'b0, 1'b0);
        check_eq("a5_dv_drop",   32'(dv0),   32'd0);
        check_eq("a5_perr_drop", 32'(perr1), 32'd0);

        // 0x07 with parity 0: wrong for even, right for odd
        send_frame(16'h07, 8, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b0);
        check_eq("x07_do",       32'(do0),   32'h07);
        check_eq("x07_dv",       32'(dv0),   32'd1);
        check_eq("x07_perr",     32'(perr0), 32'd1);
        check_eq("x07_odd_do",   32'(do1),   32'h07);
        check_eq("x07_odd_perr", 32'(perr1), 32'd0);

        // 0x3C with 3-cycle gaps between bits
        drive(1'b0, 1'b0, 1'b0);
        #1 dv_base = dv_cnt0;
        send_frame(16'h3C, 8, 1'b0, 1'b0, 3);
        drive(1'b0, 1'b0, 1'b0);
        check_eq("x3c_do",   32'(do0),   32'h3C);
        check_eq("x3c_dv",   32'(dv0),   32'd1);
        check_eq("x3c_perr", 32'(perr0), 32'd0);
        repeat (2) drive(1'b0, 1'b0, 1'b0);
        #1 check_eq("x3c_dv_count", 32'(dv_cnt0 - dv_base), 32'd1);

        // Abort after 4 bits, then a full 0x81 frame
        dv_base   = dv_cnt0;
        ferr_base = ferr_cnt0;
        drive(1'b1, 1'b1, 1'b1);
        repeat (3) drive(1'b1, 1'b0, 1'b1);
        send_frame(16'h81, 8, 1'b0, 1'b0, 0);
        check_eq("abort_do_hold", 32'(do0), 32'h3C);
        drive(1'b0, 1'b0, 1'b0);
        check_eq("x81_do",   32'(do0),   32'h81);
        check_eq("x81_dv",   32'(dv0),   32'd1);
        check_eq("x81_perr", 32'(perr0), 32'd0);
        drive(1'b0, 1'b0, 1'b0);
        #1;
        check_eq("abort_ferr_count", 32'(ferr_cnt0 - ferr_base), 32'd1);
        check_eq("abort_dv_count",   32'(dv_cnt0 - dv_base),     32'd1);

        // Clear mid-frame after 5 data bits
        drive(1'b1, 1'b1, 1'b1);
        repeat (4) drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        check_eq("pre_cd_busy", 32'(busy0), 32'd1);
        CD = 1'b1;
        #1;
        check_eq("cd_busy", 32'(busy0), 32'd0);
        check_eq("cd_dv",   32'(dv0),   32'd0);
        check_eq("cd_do",   32'(do0),   32'h0);
        CD = 1'b0;
        send_frame(16'h55, 8, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b0);
        check_eq("x55_do",   32'(do0),   32'h55);
        check_eq("x55_dv",   32'(dv0),   32'd1);
        check_eq("x55_perr", 32'(perr0), 32'd0);

        // MSB-first 4-bit: 1,0,0,0 parity 1, then back-to-back 0,1,1,0 parity 0
        drive(1'b0, 1'b0, 1'b0);
        send_frame(16'h8, 4, 1'b1, 1'b1, 0);
        drive(1'b1, 1'b1, 1'b0);
        check_eq("m8_do",   32'(do2),   32'h8);
        check_eq("m8_dv",   32'(dv2),   32'd1);
        check_eq("m8_perr", 32'(perr2), 32'd0);
        drive(1'b1, 1'b0, 1'b1);
        check_eq("m6_no_ferr", 32'(ferr2), 32'd0);
        check_eq("m6_busy",    32'(busy2), 32'd1);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        check_eq("m6_do",   32'(do2),   32'h6);
        check_eq("m6_dv",   32'(dv2),   32'd1);
        check_eq("m6_perr", 32'(perr2), 32'd0);
        check_eq("m6_busy_end", 32'(busy2), 32'd0);
        drive(1'b0, 1'b0, 1'b0);
        check_eq("m6_dv_drop", 32'(dv2), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
